// File: rtl/dsp_mac_signed_pipe_if.sv
// Sample/result bundle for dsp_mac_signed_pipe: operands and controls in, accumulator and flags out.
interface dsp_mac_if #(
  parameter int unsigned A_W   = 20,
  parameter int unsigned B_W   = 18,
  parameter int unsigned ACC_W = 38
);
  logic             valid_i;
  logic             subtract_i;
  logic             load_i;
  logic [A_W-1:0]   A;
  logic [B_W-1:0]   B;
  logic [ACC_W-1:0] P;
  logic             valid_o;
  logic             overflow_o;

  modport master (
    output valid_i, subtract_i, load_i, A, B,
    input  P, valid_o, overflow_o
  );

  modport slave (
    input  valid_i, subtract_i, load_i, A, B,
    output P, valid_o, overflow_o
  );
endinterface

// File: rtl/dsp_mac_signed_pipe.sv
// Signed multiply-accumulate: registered inputs, optional product register, add/sub accumulator
// with per-sample load, optional saturation and a sticky overflow flag.
module dsp_mac_signed_pipe #(
  parameter int unsigned A_W      = 20,
  parameter int unsigned B_W      = 18,
  parameter int unsigned ACC_W    = 38,
  parameter int unsigned MUL_PIPE = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic     clk,
  input  logic     reset,
  dsp_mac_if.slave bus
);

  localparam int unsigned PW = A_W + B_W;
  localparam int unsigned XW = ACC_W + 1 - PW;

  if (ACC_W < PW) begin : g_bad_acc_w
    $error("dsp_mac_signed_pipe: ACC_W must be >= A_W+B_W");
  end

  // Stage 1: operand and tag capture, unconditional
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic           sub_q, ld_q, vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      ld_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      sub_q <= bus.subtract_i;
      ld_q  <= bus.load_i;
      vld_q <= bus.valid_i;
    end
  end

  logic [PW-1:0] prod_c;
  assign prod_c = $signed(a_q) * $signed(b_q);

  logic [PW-1:0] m_prod;
  logic          m_sub, m_ld, m_vld;

  if (MUL_PIPE != 0) begin : g_mul_pipe
    logic [PW-1:0] prod_q;
    logic          sub2_q, ld2_q, vld2_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_q <= '0;
        sub2_q <= 1'b0;
        ld2_q  <= 1'b0;
        vld2_q <= 1'b0;
      end else begin
        prod_q <= prod_c;
        sub2_q <= sub_q;
        ld2_q  <= ld_q;
        vld2_q <= vld_q;
      end
    end

    assign m_prod = prod_q;
    assign m_sub  = sub2_q;
    assign m_ld   = ld2_q;
    assign m_vld  = vld2_q;
  end else begin : g_no_mul_pipe
    assign m_prod = prod_c;
    assign m_sub  = sub_q;
    assign m_ld   = ld_q;
    assign m_vld  = vld_q;
  end

  // Accumulator: one guard bit above ACC_W exposes overflow and the true sign of the sum
  logic [ACC_W-1:0] p_q, p_d;
  logic             ovf_q, ovf_d;
  logic             vo_q, vo_d;
  logic [ACC_W:0]   prod_ext, term, sum;
  logic             ovf_c;

  always_comb begin
    prod_ext = {{XW{m_prod[PW-1]}}, m_prod};
    term     = m_sub ? (ACC_W+1)'(-prod_ext) : prod_ext;
    sum      = {p_q[ACC_W-1], p_q} + term;
    ovf_c    = sum[ACC_W] ^ sum[ACC_W-1];
    p_d      = p_q;
    ovf_d    = ovf_q;
    vo_d     = 1'b0;
    if (m_vld) begin
      vo_d = 1'b1;
      if (m_ld) begin
        p_d   = term[ACC_W-1:0];
        ovf_d = 1'b0;
      end else if (ovf_c) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) begin
          p_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          p_d = sum[ACC_W-1:0];
        end
      end else begin
        p_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
      vo_q  <= 1'b0;
    end else begin
      p_q   <= p_d;
      ovf_q <= ovf_d;
      vo_q  <= vo_d;
    end
  end

  assign bus.P          = p_q;
  assign bus.valid_o    = vo_q;
  assign bus.overflow_o = ovf_q;

endmodule
